// File: rtl/pipelined_adder_pkg.sv
// Shared constants and configuration helpers for pipelined_adder (package adder_pkg).
// cfg_ok() backs the elaboration-time legality check instantiated by the top level.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    bit stages_ok;
    case (stages)
      1, 2, 4, 8: stages_ok = 1'b1;
      default:    stages_ok = 1'b0;
    endcase
    return stages_ok && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand and result valid/ready bundle for pipelined_adder.
// With PIPELINED_ADDER_SAT_EN defined the bundle also carries the per-beat sat bit.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_A;
  logic [WIDTH-1:0] data_B;
  logic             sub;
`ifdef PIPELINED_ADDER_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             overflow;

  modport master (
`ifdef PIPELINED_ADDER_SAT_EN
    output sat,
`endif
    output in_valid, data_A, data_B, sub, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
`ifdef PIPELINED_ADDER_SAT_EN
    input  sat,
`endif
    input  in_valid, data_A, data_B, sub, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/pipelined_adder_segment.sv
// adder_segment: one SEG-bit slice of the carry chain with registered sum, carry-out and valid.
// Only the LAST slice reports signed overflow; the others tie it low so the top can OR them.
module adder_segment #(
  parameter int SEG  = 16,
  parameter bit LAST = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           valid_i,
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic           valid_q,
  output logic [SEG-1:0] sum_q,
  output logic           cout_q,
  output logic           ovf_q
);
  logic [SEG:0]   sum_ext_s;
  logic           ovf_s;
  logic           valid_d;
  logic [SEG-1:0] sum_d;
  logic           cout_d;
  logic           ovf_d;

  assign sum_ext_s = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};

  if (LAST) begin : g_ovf
    logic msb_cin_s;
    assign msb_cin_s = sum_ext_s[SEG-1] ^ a_i[SEG-1] ^ b_i[SEG-1];
    assign ovf_s     = msb_cin_s ^ sum_ext_s[SEG];
  end else begin : g_no_ovf
    assign ovf_s = 1'b0;
  end

  // Next state: load the slice result on enable, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (en) begin
      valid_d = valid_i;
      sum_d   = sum_ext_s[SEG-1:0];
      cout_d  = sum_ext_s[SEG];
      ovf_d   = ovf_s;
    end else begin
      valid_d = valid_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
    end
  end

  // Slice state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= {SEG{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract with the carry chain split into STAGES registered segments.
// Optional PIPELINED_ADDER_SAT_EN clamps signed-overflowing results of beats sent with sat=1.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: STAGES must be 1, 2, 4 or 8 and divide WIDTH");
  end

  logic              en_s;
  logic              accept_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic [WIDTH-1:0]  res_wrap_s;
  logic [WIDTH-1:0]  res_lo_s;
  logic [STAGES-1:0] valid_s;
  logic [STAGES-1:0] cout_s;
  logic [STAGES-1:0] ovf_s;
  logic [STAGES-1:0] sub_q;
  logic [STAGES-1:0] sub_d;
  logic [SEG-1:0]    sum_s [STAGES];

  assign en_s     = !valid_s[STAGES-1] || bus.out_ready;
  assign accept_s = bus.in_valid && bus.in_ready;
  assign b_eff_s  = (bus.sub == OP_SUB) ? ~bus.data_B : bus.data_B;

  // The sub tag rides with its beat so the last stage can turn carry into borrow.
  always_comb begin
    sub_d = sub_q;
    if (en_s) begin
      sub_d[0] = bus.sub;
      for (int k = 1; k < STAGES; k++) sub_d[k] = sub_q[k-1];
    end else begin
      sub_d = sub_q;
    end
  end

  // Sub tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= {STAGES{1'b0}};
    end else begin
      sub_q <= sub_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] a_seg_s;
    logic [SEG-1:0] b_seg_s;
    logic           cin_s;
    logic           vin_s;

    if (k == 0) begin : g_head
      assign a_seg_s = bus.data_A[SEG-1:0];
      assign b_seg_s = b_eff_s[SEG-1:0];
      assign cin_s   = bus.sub;
      assign vin_s   = accept_s;
    end else begin : g_skew
      logic [SEG-1:0] a_skew_q [k];
      logic [SEG-1:0] a_skew_d [k];
      logic [SEG-1:0] b_skew_q [k];
      logic [SEG-1:0] b_skew_d [k];

      // Delay operand slice k by k cycles so it meets its carry.
      always_comb begin
        a_skew_d = a_skew_q;
        b_skew_d = b_skew_q;
        if (en_s) begin
          a_skew_d[0] = bus.data_A[k*SEG +: SEG];
          b_skew_d[0] = b_eff_s[k*SEG +: SEG];
          for (int j = 1; j < k; j++) begin
            a_skew_d[j] = a_skew_q[j-1];
            b_skew_d[j] = b_skew_q[j-1];
          end
        end else begin
          a_skew_d = a_skew_q;
          b_skew_d = b_skew_q;
        end
      end

      // Skew registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < k; j++) begin
            a_skew_q[j] <= {SEG{1'b0}};
            b_skew_q[j] <= {SEG{1'b0}};
          end
        end else begin
          a_skew_q <= a_skew_d;
          b_skew_q <= b_skew_d;
        end
      end

      assign a_seg_s = a_skew_q[k-1];
      assign b_seg_s = b_skew_q[k-1];
      assign cin_s   = cout_s[k-1];
      assign vin_s   = valid_s[k-1];
    end

    adder_segment #(
      .SEG  (SEG),
      .LAST (k == STAGES - 1)
    ) u_seg (
      .clk     (clk),
      .rst     (rst),
      .en      (en_s),
      .valid_i (vin_s),
      .a_i     (a_seg_s),
      .b_i     (b_seg_s),
      .cin_i   (cin_s),
      .valid_q (valid_s[k]),
      .sum_q   (sum_s[k]),
      .cout_q  (cout_s[k]),
      .ovf_q   (ovf_s[k])
    );

    if (k < STAGES - 1) begin : g_deskew
      localparam int DSK = STAGES - 1 - k;
      logic [SEG-1:0] dsk_q [DSK];
      logic [SEG-1:0] dsk_d [DSK];

      // Hold finished low slices until the top slice of the same beat completes.
      always_comb begin
        dsk_d = dsk_q;
        if (en_s) begin
          dsk_d[0] = sum_s[k];
          for (int j = 1; j < DSK; j++) dsk_d[j] = dsk_q[j-1];
        end else begin
          dsk_d = dsk_q;
        end
      end

      // Deskew registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < DSK; j++) dsk_q[j] <= {SEG{1'b0}};
        end else begin
          dsk_q <= dsk_d;
        end
      end

      assign res_wrap_s[k*SEG +: SEG] = dsk_q[DSK-1];
    end else begin : g_tail
      assign res_wrap_s[k*SEG +: SEG] = sum_s[k];
    end
  end

`ifdef PIPELINED_ADDER_SAT_EN
  logic [STAGES-1:0] sat_q;
  logic [STAGES-1:0] sat_d;

  // The sat tag travels with its beat exactly like sub.
  always_comb begin
    sat_d = sat_q;
    if (en_s) begin
      sat_d[0] = bus.sat;
      for (int k = 1; k < STAGES; k++) sat_d[k] = sat_q[k-1];
    end else begin
      sat_d = sat_q;
    end
  end

  // Sat tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= {STAGES{1'b0}};
    end else begin
      sat_q <= sat_d;
    end
  end

  // A wrapped negative-looking result means positive overflow, so clamp to max.
  always_comb begin
    res_lo_s = res_wrap_s;
    if (sat_q[STAGES-1] && (|ovf_s)) begin
      if (res_wrap_s[WIDTH-1]) begin
        res_lo_s = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        res_lo_s = {1'b1, {(WIDTH-1){1'b0}}};
      end
    end else begin
      res_lo_s = res_wrap_s;
    end
  end
`else
  assign res_lo_s = res_wrap_s;
`endif

  assign bus.result    = {cout_s[STAGES-1] ^ sub_q[STAGES-1], res_lo_s};
  assign bus.overflow  = |ovf_s;
  assign bus.out_valid = valid_s[STAGES-1];
  assign bus.in_ready  = en_s && !rst;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=32, STAGES=2 with hand-computed vectors.
// Defining PIPELINED_ADDER_SAT_EN also exercises the saturating clamp.
module tb_pipelined_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int NVEC   = 12;

  typedef struct {
    logic [WIDTH:0] res;
    logic           ovf;
    int             acc;
    bit             lat;
  } exp_t;

  localparam logic [31:0] VA [NVEC] = '{
    32'h0000_4234, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005,
    32'h8000_0000, 32'h0000_FFFF, 32'h0000_0000, 32'h8000_0000,
    32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 32'h7FFF_FFFF};
  localparam logic [31:0] VB [NVEC] = '{
    32'h0000_5678, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007,
    32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000,
    32'h0000_0020, 32'h8765_4321, 32'h0000_BEEF, 32'hFFFF_FFFF};
  localparam logic VS [NVEC] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [32:0] VR [NVEC] = '{
    33'h0_0000_98AC, 33'h1_0000_0000, 33'h0_8000_0000, 33'h1_FFFF_FFFE,
    33'h0_7FFF_FFFF, 33'h0_0001_0000, 33'h0_0000_0000, 33'h1_0000_0000,
    33'h1_FFFF_FFF0, 33'h0_9999_9999, 33'h0_DEAD_0000, 33'h1_8000_0000};
  localparam logic VO [NVEC] = '{
    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  exp_t           sb_q [$];
  bit             held = 1'b0;
  logic [WIDTH:0] held_res;
  logic           held_ovf;
  bit             toggle_en = 1'b0;
  logic [15:0]    rdy_pat = 16'b1011_0010_1110_0101;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic st,
                      input logic [32:0] er, input logic eo, input bit lat, input bit first_try);
    int   waits = 0;
    bit   done  = 1'b0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.data_A   = a;
    bus.data_B   = b;
    bus.sub      = s;
`ifdef PIPELINED_ADDER_SAT_EN
    bus.sat      = st;
`endif
    while (!done && waits < 100) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.res = er;
        e.ovf = eo;
        e.acc = cyc;
        e.lat = lat;
        sb_q.push_back(e);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accepted", done, 1'b1);
    if (first_try) chk("full_rate_accept_waits", waits, 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_outstanding", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every consumed beat and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_out_valid", bus.out_valid, 1'b1);
        chk("stall_result", bus.result, held_res);
        chk("stall_overflow", bus.overflow, held_ovf);
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", bus.in_ready, 1'b0);
        held     = 1'b1;
        held_res = bus.result;
        held_ovf = bus.overflow;
      end else begin
        held = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got result 0x%0h, expected no beat (t=%0t)", bus.result, $time);
        end else begin
          e = sb_q.pop_front();
          chk("result", bus.result, e.res);
          chk("overflow", bus.overflow, e.ovf);
          if (e.lat) chk("latency", cyc - e.acc, STAGES);
        end
      end
    end
  end

  // Pseudo-random backpressure pattern while toggle_en is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) bus.out_ready = rdy_pat[cyc % 16];
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_A    = 32'h0;
    bus.data_B    = 32'h0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SAT_EN
    bus.sat       = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_result", bus.result, 33'h0);
    chk("reset_overflow", bus.overflow, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed vectors back to back at full rate, latency checked on each.
    for (int i = 0; i < NVEC; i++) begin
      send(VA[i], VB[i], VS[i], 1'b0, VR[i], VO[i], 1'b1, 1'b1);
    end
    drain(50);

    // 16-beat stream under toggling backpressure.
    toggle_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(VA[i % NVEC], VB[i % NVEC], VS[i % NVEC], 1'b0, VR[i % NVEC], VO[i % NVEC], 1'b0, 1'b0);
    end
    toggle_en     = 1'b0;
    bus.out_ready = 1'b1;
    drain(200);

    // Reset with two beats in flight must flush them.
    bus.out_ready = 1'b0;
    send(VA[0], VB[0], VS[0], 1'b0, VR[0], VO[0], 1'b0, 1'b1);
    send(VA[1], VB[1], VS[1], 1'b0, VR[1], VO[1], 1'b0, 1'b1);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("in_ready_during_reset", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    send(VA[2], VB[2], VS[2], 1'b0, VR[2], VO[2], 1'b1, 1'b1);
    drain(50);

`ifdef PIPELINED_ADDER_SAT_EN
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 33'h0_7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 33'h0_8000_0000, 1'b1, 1'b1, 1'b1);
    send(32'h0000_4234, 32'h0000_5678, 1'b0, 1'b1, 33'h0_0000_98AC, 1'b0, 1'b1, 1'b1);
    drain(50);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit, successor to `adder_top`. Operands are accepted on a valid/ready handshake, and the carry chain is split into `STAGES` registered segments. Results leave through a second valid/ready port with full backpressure. It sits between operand producers and result consumers in datapaths that need a single-cycle issue rate at widths where one combinational carry chain no longer closes timing.

## Interface
- `WIDTH`, 32: operand width in bits; must be a multiple of `STAGES`.
- `STAGES`, 2: pipeline segments and latency in cycles; legal values are 1, 2, 4 and 8.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts an operand beat this cycle.
- `data_A`  in  WIDTH  operand A.
- `data_B`  in  WIDTH  operand B.
- `sub`  in  1  0 = A+B, 1 = A−B; sampled with the operands.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH+1  sum or difference; bit WIDTH is carry-out (add) or borrow (sub).
- `overflow`  out  1  two's-complement signed overflow of `result[WIDTH-1:0]`.

## Operation
- Segment width is `SEG = WIDTH/STAGES`. Stage k adds operand bits [k·SEG +: SEG] plus the registered carry from stage k−1.
- Higher operand slices are delayed by skew registers; lower result slices are delayed by deskew registers, so all slices of one beat exit together.
- Subtraction computes `A + ~B + 1`. The `sub` bit travels with the beat and injects carry-in=1 at stage 0.
  - `result[WIDTH]` = final carry for add.
  - `result[WIDTH]` = inverted final carry (borrow) for sub.
- `overflow` = carry into the MSB XOR carry out of the MSB, computed in the last stage.
- Pipeline enable: `en = !out_valid || out_ready`.
  - `in_ready = en && !rst`.
  - Every stage register, including its valid bit, advances only when `en` is high.
  - Bubbles (valid=0) propagate like data; data registers of bubbles may hold any value.
- Transfer rules:
  - An input beat is accepted when `in_valid && in_ready`.
  - An output beat is consumed when `out_valid && out_ready`.
- No FSM: each stage carries one valid bit, and `out_valid` is the last stage's valid.

## Timing
- Latency: `STAGES` cycles from acceptance to `out_valid`, given no stall.
- Throughput: one beat per cycle while `out_ready` is held high.
- Stall: while `out_valid && !out_ready`, all stages hold. `result`, `overflow` and `out_valid` stay stable and `in_ready` is 0.
- Simultaneous consume and accept in the same cycle is legal and sustains full rate.
- Reset values: every stage valid bit = 0, `out_valid` = 0, `result` = 0, `overflow` = 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after reset.
- Reset mid-operation flushes all in-flight beats; no partial result is emitted.
- `STAGES=1` degenerates to one registered adder with latency 1.

## Configuration
- `PIPELINED_ADDER_SAT_EN` defined:
  - Adds input `sat` (1 bit), sampled with the operands.
  - When `sat=1` and `overflow=1`, `result[WIDTH-1:0]` clamps to the signed maximum (positive overflow) or signed minimum (negative overflow).
  - `result[WIDTH]` and `overflow` still report the raw values.
  - The clamp is applied in the last stage and adds no latency.
- Not defined: no `sat` port; results always wrap modulo 2^WIDTH.

## Structure
- Package `adder_pkg` holds:
  - localparam `OP_ADD=1'b0`, `OP_SUB=1'b1`;
  - function `seg_width(WIDTH, STAGES)`;
  - a compile-time check that `WIDTH % STAGES == 0`.
- Sub-module `adder_segment`:
  - one SEG-bit slice with a registered sum, carry-out and valid, gated by `en`;
  - instantiated `STAGES` times in a generate loop;
  - the top level owns the skew/deskew registers and the handshake.

## Test plan
- WIDTH=32, STAGES=2, `out_ready`=1: A=0x4234, B=0x5678, sub=0 → after 2 cycles `result`=0x0_000098AC, `overflow`=0.
- A=0xFFFFFFFF, B=0x1, add → `result`=0x1_00000000 (carry set), `overflow`=0. Then A=0x7FFFFFFF, B=0x1 → `result`=0x0_80000000, `overflow`=1.
- Sub: A=0x5, B=0x7 → `result`=0x1_FFFFFFFE (borrow set), `overflow`=0. A=0x80000000, B=0x1 → `overflow`=1.
- Back-to-back stream of 16 beats, `out_ready` toggled pseudo-randomly:
  - results appear in order with no loss or duplication;
  - `result` holds stable whenever `out_valid && !out_ready`.
- Assert `rst` for 1 cycle with 2 beats in flight → `out_valid`=0 next cycle, no stale beat emitted, `in_ready`=1 after deassert.
- With `PIPELINED_ADDER_SAT_EN`: A=0x7FFFFFFF, B=0x1, sat=1 → `result[31:0]`=0x7FFFFFFF, `overflow`=1. A=0x80000000, B=0x1, sub, sat=1 → `result[31:0]`=0x80000000.
